// File: rtl/dmem_pkg.sv
// Shared width codes, FSM state type and alignment helper for the data-memory path.
package dmem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        return (width == 2'b11)
            || ((width == W_HALF) && addr_lo[0])
            || ((width == W_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends a byte/half/word from a bus read word according to the byte offset.
module lsu_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic        ext_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    // ext_i=1 selects zero-extension, so the fill bit is the sign bit only when ext_i=0
    always_comb begin
        data_o = '0;
        unique case (width_i)
            W_BYTE:  data_o = {{24{~ext_i & shifted[7]}}, shifted[7:0]};
            W_HALF:  data_o = {{16{~ext_i & shifted[15]}}, shifted[15:0]};
            W_WORD:  data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: accepts one core request, runs a req/gnt/rvalid bus transaction and
// returns aligned load data or a store ack, flagging misalignment and bus timeouts.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              w_ena_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        width_i,
    input  logic              ext_i,
    input  logic [31:0]       data_in_i,
    output logic              resp_valid_o,
    output logic [31:0]       data_out_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        width_q, width_d;
    logic              ext_q, ext_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic [31:0]       data_out_q, data_out_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              rsp_done;
    logic [31:0]       load_data;

    lsu_load_align u_load_align (
        .rdata_i   (mem_rdata_i),
        .addr_lo_i (addr_lo_q),
        .width_i   (width_q),
        .ext_i     (ext_q),
        .data_o    (load_data)
    );

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == TimeoutCnt);
    // rvalid only counts in REQ when the grant arrives in the same cycle
    assign rsp_done    = (state_q == REQ) ? (mem_gnt_i & mem_rvalid_i) : mem_rvalid_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_lo_d    = addr_lo_q;
        width_d      = width_q;
        ext_d        = ext_q;
        we_d         = we_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        err_d        = err_q;
        data_out_d   = data_out_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_lo_d  = addr_i[1:0];
                    width_d    = width_i;
                    ext_d      = ext_i;
                    we_d       = w_ena_i;
                    cnt_d      = '0;
                    data_out_d = '0;
                    if (misaligned(width_i, addr_i[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        state_d     = REQ;
                        err_d       = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = w_ena_i;
                        mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = 4'b0000;
                        if (w_ena_i) begin
                            unique case (width_i)
                                W_BYTE: begin
                                    mem_wstrb_d = 4'b0001 << addr_i[1:0];
                                    mem_wdata_d = {4{data_in_i[7:0]}};
                                end
                                W_HALF: begin
                                    mem_wstrb_d = 4'b0011 << addr_i[1:0];
                                    mem_wdata_d = {2{data_in_i[15:0]}};
                                end
                                default: begin
                                    mem_wstrb_d = 4'b1111;
                                    mem_wdata_d = data_in_i;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_inc;
                if (rsp_done) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    err_d        = 1'b0;
                    data_out_d   = we_q ? 32'h0 : load_data;
                end else if (timeout_hit) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                    err_d        = 1'b1;
                    data_out_d   = '0;
                end else if ((state_q == REQ) && mem_gnt_i) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_lo_q    <= '0;
            width_q      <= '0;
            ext_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_lo_q    <= addr_lo_d;
            width_q      <= width_d;
            ext_q        <= ext_d;
            we_q         <= we_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            data_out_q   <= data_out_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign data_out_o   = data_out_q;
    assign err_o        = err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu; a second instance with a short timeout covers the abort path.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_t;
    logic        w_ena, ext;
    logic [31:0] addr, data_in;
    logic [1:0]  width;
    logic        gnt, rvalid, gnt_t, rvalid_t;
    logic [31:0] rdata;

    logic        req_ready, resp_valid, err, mem_req, mem_we;
    logic [31:0] data_out, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        req_ready_t, resp_valid_t, err_t, mem_req_t, mem_we_t;
    logic [31:0] data_out_t, mem_addr_t, mem_wdata_t;
    logic [3:0]  mem_wstrb_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t sb_q[$];
    int    checks = 0;
    int    failures = 0;
    int    resp_cnt_t = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(32), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .w_ena_i(w_ena), .addr_i(addr), .width_i(width), .ext_i(ext), .data_in_i(data_in),
        .resp_valid_o(resp_valid), .data_out_o(data_out), .err_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata)
    );

    dmem_lsu #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(8)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid_t), .req_ready_o(req_ready_t),
        .w_ena_i(w_ena), .addr_i(addr), .width_i(width), .ext_i(ext), .data_in_i(data_in),
        .resp_valid_o(resp_valid_t), .data_out_o(data_out_t), .err_o(err_t),
        .mem_req_o(mem_req_t), .mem_we_o(mem_we_t), .mem_addr_o(mem_addr_t),
        .mem_wstrb_o(mem_wstrb_t), .mem_wdata_o(mem_wdata_t),
        .mem_gnt_i(gnt_t), .mem_rvalid_i(rvalid_t), .mem_rdata_i(rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [31:0] a, input logic [1:0] w,
                           input logic e, input logic [31:0] d);
        req_valid = 1'b1;
        w_ena     = we;
        addr      = a;
        width     = w;
        ext       = e;
        data_in   = d;
    endtask

    task automatic push_exp(input logic e, input logic [31:0] d);
        resp_t r;
        r.err  = e;
        r.data = d;
        sb_q.push_back(r);
    endtask

    // Response scoreboard and busy-ready monitor for the main instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = sb_q.pop_front();
                    check_eq("resp_err", {31'd0, err}, {31'd0, e.err});
                    check_eq("resp_data", data_out, e.data);
                end
            end
            if (resp_valid || mem_req) check_eq("ready_busy", {31'd0, req_ready}, 32'd0);
            if (resp_valid_t) resp_cnt_t++;
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid_t = 1'b0;
        w_ena = 1'b0; addr = '0; width = 2'b00; ext = 1'b0; data_in = '0;
        gnt = 1'b0; rvalid = 1'b0; gnt_t = 1'b0; rvalid_t = 1'b0; rdata = '0;
        #12;
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_data_out", data_out, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_ready", {31'd0, req_ready}, 32'd1);

        // Signed and unsigned byte loads from the top lane
        for (int k = 0; k < 2; k++) begin
            set_req(1'b0, 32'h1003, 2'b00, k[0], 32'h0);
            push_exp(1'b0, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            tick();
            req_valid = 1'b0;
            check_eq("lb_mem_req", {31'd0, mem_req}, 32'd1);
            check_eq("lb_mem_addr", mem_addr, 32'h1000);
            check_eq("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
            check_eq("lb_we", {31'd0, mem_we}, 32'd0);
            gnt = 1'b1; rvalid = 1'b1; rdata = 32'h80FF_1234;
            tick();
            gnt = 1'b0; rvalid = 1'b0;
            check_eq("lb_latency", {31'd0, resp_valid}, 32'd1);
            check_eq("lb_req_drop", {31'd0, mem_req}, 32'd0);
            tick();
            check_eq("lb_pulse", {31'd0, resp_valid}, 32'd0);
            check_eq("lb_hold", data_out, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        // Store half with a stalled grant, acked in WAIT
        set_req(1'b1, 32'h2002, 2'b01, 1'b0, 32'hDEAD_BEEF);
        push_exp(1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        check_eq("sh_we", {31'd0, mem_we}, 32'd1);
        check_eq("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check_eq("sh_addr", mem_addr, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("sh_req_held", {31'd0, mem_req}, 32'd1);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        check_eq("sh_wait_req", {31'd0, mem_req}, 32'd0);
        check_eq("sh_wait_resp", {31'd0, resp_valid}, 32'd0);
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        check_eq("sh_resp", {31'd0, resp_valid}, 32'd1);
        tick();

        // Misaligned word and illegal width: one-cycle error response, no bus request
        set_req(1'b0, 32'h3001, 2'b10, 1'b0, 32'h0);
        push_exp(1'b1, 32'h0);
        tick();
        req_valid = 1'b0;
        check_eq("mis_resp", {31'd0, resp_valid}, 32'd1);
        check_eq("mis_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        set_req(1'b0, 32'h3000, 2'b11, 1'b0, 32'h0);
        push_exp(1'b1, 32'h0);
        tick();
        req_valid = 1'b0;
        check_eq("ill_resp", {31'd0, resp_valid}, 32'd1);
        check_eq("ill_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        check_eq("ill_err_hold", {31'd0, err}, 32'd1);

        // Timeout on the short-timeout instance, then late bus traffic
        set_req(1'b0, 32'h44, 2'b10, 1'b0, 32'h0);
        req_valid = 1'b0;
        req_valid_t = 1'b1;
        tick();
        req_valid_t = 1'b0;
        check_eq("to_ready", {31'd0, req_ready_t}, 32'd0);
        check_eq("to_addr", mem_addr_t, 32'h44);
        check_eq("to_we", {27'd0, mem_we_t, mem_wstrb_t}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("to_req_held", {31'd0, mem_req_t}, 32'd1);
            check_eq("to_no_resp", {31'd0, resp_valid_t}, 32'd0);
            tick();
        end
        check_eq("to_resp", {31'd0, resp_valid_t}, 32'd1);
        check_eq("to_err", {31'd0, err_t}, 32'd1);
        check_eq("to_data", data_out_t, 32'd0);
        check_eq("to_req_drop", {31'd0, mem_req_t}, 32'd0);
        gnt_t = 1'b1; rvalid_t = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("to_late_ignored", {31'd0, resp_valid_t}, 32'd0);
        end
        gnt_t = 1'b0; rvalid_t = 1'b0;
        check_eq("to_resp_count", resp_cnt_t, 32'd1);
        check_eq("to_wdata_untouched", mem_wdata_t, 32'd0);

        // Asynchronous reset mid-REQ and mid-WAIT
        set_req(1'b1, 32'h50, 2'b10, 1'b0, 32'h1234_5678);
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_drop", {31'd0, mem_req}, 32'd0);
        check_eq("arst_wdata", mem_wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(1'b0, 32'h60, 2'b10, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wait_req", {31'd0, mem_req}, 32'd0);
        check_eq("arst_wait_resp", {31'd0, resp_valid}, 32'd0);
        check_eq("arst_wait_err", {31'd0, err}, 32'd0);
        check_eq("arst_wait_addr", mem_addr, 32'd0);
        check_eq("arst_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
        set_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        push_exp(1'b0, 32'hA5C3_0F17);
        tick();
        req_valid = 1'b0;
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'hA5C3_0F17;
        tick();
        gnt = 1'b0; rvalid = 1'b0;
        check_eq("post_rst_resp", {31'd0, resp_valid}, 32'd1);
        tick();

        // Back-to-back loads with req_valid held high
        set_req(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        push_exp(1'b0, 32'h8001_7FFE);
        tick();
        set_req(1'b0, 32'h42, 2'b01, 1'b0, 32'h0);
        push_exp(1'b0, 32'hFFFF_8001);
        check_eq("b2b_ready_req", {31'd0, req_ready}, 32'd0);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'h8001_7FFE;
        tick();
        gnt = 1'b0; rvalid = 1'b0;
        check_eq("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        check_eq("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        tick();
        check_eq("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        check_eq("b2b_no_req_yet", {31'd0, mem_req}, 32'd0);
        tick();
        req_valid = 1'b0;
        check_eq("b2b_accept2", {31'd0, mem_req}, 32'd1);
        check_eq("b2b_addr2", mem_addr, 32'h40);
        gnt = 1'b1; rvalid = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b0;
        check_eq("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        tick();
        tick();

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the core's memory-access stage and a word-wide data-memory bus. Takes one request per transaction (address, width, sign mode, store data) and checks alignment. Drives a request/grant/response bus with byte strobes. Returns aligned, extended load data or a store acknowledge, with an error flag for misalignment or a bus timeout.

Parameters:
ADDR_W, 32, byte-address width on both sides
TIMEOUT, 255, max cycles spent in REQ+WAIT before the transaction aborts with err
CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  unit can accept; high only in IDLE
w_ena  in  1  1 = store, 0 = load
addr  in  ADDR_W  byte address (ALU result)
width  in  2  00 byte, 01 half, 10 word, 11 illegal
ext  in  1  funct3[2]: 1 = zero-extend, 0 = sign-extend (loads only)
data_in  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
data_out  out  32  load result; 0 for stores and errors
err  out  1  qualifies resp_valid: misaligned, illegal width, or timeout
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  word-aligned address, low two bits 0
mem_wstrb  out  4  byte lane strobes; 0000 on reads
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  bus accepted the request this cycle
mem_rvalid  in  1  read data valid or write acknowledged
mem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs are registered except req_ready, which equals (state==IDLE).
- Reset (async, rst=0):
  - State goes to IDLE.
  - mem_req, mem_we, mem_wstrb, resp_valid and err go to 0. mem_addr, mem_wdata and data_out go to 0.
  - Any in-flight transaction is abandoned. mem_req drops immediately.
- Request latch: on the accept edge (req_valid & req_ready), latch addr[1:0], width, ext and w_ena. The timeout counter clears to 0.
- Misalignment:
  - Misaligned when width==11, or width==01 & addr[0], or width==10 & addr[1:0]!=0.
  - A misaligned request goes IDLE->RESP and never asserts mem_req. In RESP: resp_valid=1, err=1, data_out=0.
- Aligned request, IDLE->REQ:
  - mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_we=w_ena.
  - Store byte: wstrb=0001<<addr[1:0], wdata={4{data_in[7:0]}}.
  - Store half: wstrb=0011<<addr[1:0], wdata={2{data_in[15:0]}}.
  - Store word: wstrb=1111, wdata=data_in.
  - Load: wstrb=0000.
- REQ:
  - mem_gnt=1 & mem_rvalid=0 -> WAIT, mem_req cleared.
  - mem_gnt=1 & mem_rvalid=1 in the same cycle -> RESP directly.
  - mem_rvalid without mem_gnt is ignored.
- WAIT: mem_rvalid=1 -> RESP. The same response path applies to stores (ack) and loads.
- Load data:
  - Byte b = mem_rdata >> (8*addr[1:0]), low 8 bits. Half h = mem_rdata >> (8*addr[1:0]), low 16 bits.
  - Extended by bit 7 or bit 15 when ext=0, zero-extended when ext=1. Word is passed through.
  - data_out is registered on the RESP entry edge. Stores give data_out=0.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT while still in REQ or WAIT, go to RESP with err=1, data_out=0, mem_req=0.
  - A late mem_gnt or mem_rvalid arriving in IDLE or RESP is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. data_out and err hold until the next accept; resp_valid does not.
- Latency: the minimum is accept edge -> resp_valid 2 cycles later (gnt and rvalid in the first REQ cycle). A misaligned request gives resp_valid 1 cycle after accept.
- Throughput: req_ready=0 from REQ through RESP. Back-to-back requests are accepted in the IDLE cycle after RESP.

Decomposition:
- Shared package dmem_pkg holds:
  - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10;
  - the lsu_state_t enum {IDLE, REQ, WAIT, RESP};
  - a misaligned(width, addr_lo) function.
- One combinational sub-module, lsu_load_align (rdata, addr_lo, width, ext -> data_out), is reused later by the icache fill path.
- Strobe and replication logic stays inline.

Test Plan:
- Load byte, addr=0x1003, ext=0, mem_rdata=0x80FF_1234, gnt+rvalid in the first REQ cycle -> mem_addr=0x1000, wstrb=0000, resp_valid 2 cycles after accept, data_out=0xFFFF_FF80, err=0. Repeat with ext=1 -> data_out=0x0000_0080.
- Store half, addr=0x2002, data_in=0xDEAD_BEEF -> mem_we=1, wstrb=1100, mem_wdata=0xBEEF_BEEF, mem_req held through 3 cycles of gnt=0; ack in WAIT -> resp_valid=1, data_out=0.
- Load word, addr=0x3001 -> no mem_req ever, resp_valid 1 cycle after accept, err=1, data_out=0. Also width=11 at addr=0x3000 -> err=1.
- TIMEOUT=4, gnt never asserted -> mem_req drops, resp_valid with err=1 exactly 4 cycles after entering REQ. A late rvalid afterwards causes no extra resp_valid.
- Assert rst=0 mid-WAIT -> mem_req, resp_valid and err go to 0 immediately (asynchronously, no clock edge). After release, req_ready=1 and a new load word at 0x0 returns mem_rdata unchanged.
- Two back-to-back loads with req_valid held high -> second accept occurs in the IDLE cycle after RESP, and req_ready is never high in REQ, WAIT or RESP.
